mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of cycles Busy stays high for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: number of cycles Busy stays high for div/divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 Start  input  1  E-stage pulse; launches the mult/div operation selected by MDUsel.
REQ-006 MDUsel  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi; 7 is reserved and treated as none.
REQ-007 MDU_RDsel  input  1  read select: 0 LO, 1 HI.
REQ-008 A  input  32  forwarded rs operand (multiplicand, dividend, or mtlo/mthi data).
REQ-009 B  input  32  forwarded rt operand (multiplier or divisor).
REQ-010 Busy  output  1  registered; high while an operation is in flight.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 RD  output  32  combinational read data: HI when MDU_RDsel=1, else LO.

Function
REQ-014 The block SHALL have two states: IDLE (Busy=0) and RUN (Busy=1), with a down-counter cnt of 4 bits.
REQ-015 In IDLE, Start=1 with MDUsel 1..4 SHALL, at that edge: latch the computed 64-bit result into pending registers, enter RUN, and load cnt with N-1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 Busy SHALL be high for exactly N consecutive cycles after the launching edge.
REQ-017 In RUN, each edge with cnt≠0 SHALL decrement cnt.
REQ-018 In RUN, the edge with cnt=0 SHALL commit pending to HI/LO and return to IDLE, so Busy falls and the new values appear in the same cycle.
REQ-019 HI/LO SHALL hold their old values throughout RUN; RD during RUN returns old values.
REQ-020 mult SHALL compute a signed 32x32 -> 64-bit product, with HI = [63:32] and LO = [31:0].
REQ-021 multu SHALL compute the same product unsigned.
REQ-022 div SHALL compute a signed quotient into LO (truncated toward zero) and the remainder into HI (sign of the dividend).
REQ-023 For div, 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 divu SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-025 For div/divu with B=0, the block SHALL still run DIV_CYCLES busy cycles, then leave HI and LO unchanged.
REQ-026 In IDLE, MDUsel=5 SHALL write LO<=A at the next edge, with no Busy.
REQ-027 In IDLE, MDUsel=6 SHALL write HI<=A at the next edge, with no Busy.
REQ-028 mtlo/mthi SHALL NOT depend on Start.
REQ-029 Start, mtlo and mthi arriving while in RUN SHALL be ignored; upstream stalls on (Start | Busy) for any MDU-class instruction in D.
REQ-030 Start with MDUsel 0, 5, 6 or 7 SHALL NOT launch RUN.

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, cnt=0, Busy=0, HI=0, LO=0, and pending=0.
REQ-032 A reset asserted in RUN SHALL abort the operation with no commit.
REQ-033 Release of reset SHALL take effect at the next clk edge.

Structure
REQ-034 A shared package SHALL hold the MDUsel encodings (MDU_NONE..MDU_MTHI), the MULT_CYCLES/DIV_CYCLES defaults, and the RD select encodings, shared with the decoder.
REQ-035 One combinational sub-module, mdu_calc, SHALL map (MDUsel, A, B) to a 64-bit {hi, lo} result and a div-by-zero flag.
REQ-036 The mdu top SHALL own the FSM, counter, pending registers and HI/LO.

Verification
REQ-037 Scenario, mult: A=0xFFFFFFFE, B=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-038 Scenario, multu: A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE; Busy falls in the same cycle HI/LO update.
REQ-039 Scenario, div: A=-7 (0xFFFFFFF9), B=2 -> Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-040 Scenario, div edge cases: div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; divu 5/0 -> 10 busy cycles, then HI/LO unchanged.
REQ-041 Scenario, mthi/mtlo: mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> RD with MDU_RDsel=1 gives 0x12345678 and 0 gives 0x9ABCDEF0; Busy stays 0.
REQ-042 Scenario, reset mid-run: launch mult 2x3, drop reset at busy cycle 3 -> Busy, HI and LO become 0 immediately; after release, no commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU encodings: operation select, read select, default latencies and FSM states.
// The instruction decoder imports this package too.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MTHI  = 3'd6;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {StIdle, StRun} mdu_state_e;

  // True for the four operations that occupy the unit for several cycles.
  function automatic logic is_launch(input logic [2:0] sel);
    return (sel >= MDU_MULT) && (sel <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: maps (sel, a, b) to a 64-bit {hi, lo} result.
// Division runs on magnitudes and re-applies signs, so 0x80000000 / -1 wraps to 0x80000000.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        signed_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] safe_den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  assign signed_div = (sel == MDU_DIV);

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign num      = (signed_div && a[31]) ? -a : a;
  assign den      = (signed_div && b[31]) ? -b : b;
  // Divisor of zero is replaced so the divider never sees it; the flag suppresses the commit.
  assign safe_den = (den == 32'd0) ? 32'd1 : den;
  assign uq       = num / safe_den;
  assign ur       = num % safe_den;
  assign q        = (signed_div && (a[31] ^ b[31])) ? -uq : uq;
  assign r        = (signed_div && a[31]) ? -ur : ur;

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (sel)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV, MDU_DIVU: begin
        result   = {r, q};
        div_zero = (b == 32'd0);
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: latches the result at launch, holds Busy for a fixed latency,
// then commits to HI/LO on the same edge Busy falls. mtlo/mthi write directly when idle.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUsel,
  input  logic        MDU_RDsel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_dz_q, pend_dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic [63:0] calc_result;
  logic        calc_dz;

  mdu_calc u_calc (
    .sel      (MDUsel),
    .a        (A),
    .b        (B),
    .result   (calc_result),
    .div_zero (calc_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start && is_launch(MDUsel)) begin
          state_d   = StRun;
          cnt_d     = ((MDUsel == MDU_MULT) || (MDUsel == MDU_MULTU)) ? MultLoad : DivLoad;
          pend_d    = calc_result;
          pend_dz_d = calc_dz;
        end else if (MDUsel == MDU_MTLO) begin
          lo_d = A;
        end else if (MDUsel == MDU_MTHI) begin
          hi_d = A;
        end
      end
      StRun: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          if (!pend_dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_dz_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign RD   = (MDU_RDsel == RD_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected busy length and HI/LO per operation,
// a monitor checks hold-during-run and the commit when Busy falls.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDUsel;
  logic        MDU_RDsel;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] RD;

  typedef struct {
    int unsigned n;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  mdu dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .MDUsel    (MDUsel),
    .MDU_RDsel (MDU_RDsel),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .HI        (HI),
    .LO        (LO),
    .RD        (RD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 1ns after each rising edge.
  initial begin
    logic  prev_busy = 1'b0;
    logic  in_flight = 1'b0;
    int    busy_cnt  = 0;
    exp_t  cur;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (in_flight) begin
          void'(sb.pop_front());
          in_flight = 1'b0;
        end
        prev_busy = 1'b0;
      end else begin
        if (Busy && !prev_busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy: Busy=1 with no operation issued");
          end else begin
            cur       = sb[0];
            in_flight = 1'b1;
            busy_cnt  = 1;
            chk("hold_hi", HI, cur.old_hi);
            chk("hold_lo", LO, cur.old_lo);
            chk("hold_rd", RD, cur.old_lo);
          end
        end else if (Busy) begin
          busy_cnt++;
        end else if (prev_busy && in_flight) begin
          cur       = sb.pop_front();
          in_flight = 1'b0;
          chk("busy_len", busy_cnt, cur.n);
          chk("commit_hi", HI, cur.hi);
          chk("commit_lo", LO, cur.lo);
        end
        prev_busy = Busy;
      end
    end
  end

  task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned n, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    @(negedge clk);
    Start  = 1'b1;
    MDUsel = sel;
    A      = a;
    B      = b;
    e = '{n, eh, el, cur_hi, cur_lo};
    sb.push_back(e);
    @(negedge clk);
    Start  = 1'b0;
    MDUsel = MDU_NONE;
    cur_hi = eh;
    cur_lo = el;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!Busy) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: Busy still 1 after 40 cycles, expected 0");
    end
  endtask

  initial begin
    reset     = 1'b0;
    Start     = 1'b0;
    MDUsel    = MDU_NONE;
    MDU_RDsel = RD_LO;
    A         = 32'd0;
    B         = 32'd0;
    #3;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_rd", RD, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(MDU_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA); wait_idle();
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE); wait_idle();
    issue(MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD); wait_idle();
    issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000); wait_idle();
    issue(MDU_DIVU,  32'd5,        32'd0,        10, 32'h00000000, 32'h80000000); wait_idle();
    issue(MDU_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E); wait_idle();
    issue(MDU_MULT,  32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB); wait_idle();

    // Launch, then present mtlo and a div Start while busy; both must be ignored.
    issue(MDU_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    Start  = 1'b1;
    MDUsel = MDU_MTLO;
    A      = 32'h0000DEAD;
    @(negedge clk);
    MDUsel = MDU_DIV;
    B      = 32'd1;
    @(negedge clk);
    Start  = 1'b0;
    MDUsel = MDU_NONE;
    wait_idle();

    // Start with non-launching selects.
    @(negedge clk);
    Start  = 1'b1;
    MDUsel = MDU_NONE;
    @(negedge clk);
    chk("nolaunch0_busy", {31'd0, Busy}, 32'd0);
    MDUsel = 3'd7;
    @(negedge clk);
    chk("nolaunch7_busy", {31'd0, Busy}, 32'd0);
    chk("nolaunch_hi", HI, cur_hi);
    chk("nolaunch_lo", LO, cur_lo);
    Start  = 1'b0;
    MDUsel = MDU_NONE;

    // mthi then mtlo.
    @(negedge clk);
    MDUsel = MDU_MTHI;
    A      = 32'h12345678;
    @(negedge clk);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    chk("mthi_hi", HI, 32'h12345678);
    MDUsel = MDU_MTLO;
    A      = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);
    MDUsel    = MDU_NONE;
    MDU_RDsel = RD_HI;
    #1;
    chk("rd_hi", RD, 32'h12345678);
    MDU_RDsel = RD_LO;
    #1;
    chk("rd_lo", RD, 32'h9ABCDEF0);
    cur_hi = 32'h12345678;
    cur_lo = 32'h9ABCDEF0;

    // Reset during busy cycle 3 aborts without commit.
    issue(MDU_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (8) @(negedge clk);
    chk("post_abort_busy", {31'd0, Busy}, 32'd0);
    chk("post_abort_hi", HI, 32'd0);
    chk("post_abort_lo", LO, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
